muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit implementing the RISC-V M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Parametrised in operand width.
- Replaces the single-cycle combinational mul/div/rem paths beside the ALU, so those ops leave the critical path.
- The CPU core issues an op through a valid/ready handshake, stalls, and takes the result through a second valid/ready handshake.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_fixup.sv | 52 +++++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_fixup.sv
// Operand magnitude/sign extraction at accept time, and sign correction plus
// result selection from the final accumulator.
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        i_in_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [XLEN-1:0]   o_a_mag,
  output logic [XLEN-1:0]   o_b_mag,
  output logic              o_neg,
  input  logic [2:0]        i_res_op,
  input  logic              i_res_neg,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [XLEN-1:0]   o_result
);

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sa;
  logic              w_sb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  assign w_a_signed = (i_in_op == MD_MULH) || (i_in_op == MD_MULHSU) ||
                      (i_in_op == MD_DIV)  || (i_in_op == MD_REM);
  assign w_b_signed = (i_in_op == MD_MULH) || (i_in_op == MD_DIV) || (i_in_op == MD_REM);
  assign w_sa       = w_a_signed & i_a[XLEN-1];
  assign w_sb       = w_b_signed & i_b[XLEN-1];
  assign o_a_mag    = w_sa ? -i_a : i_a;
  assign o_b_mag    = w_sb ? -i_b : i_b;
  // Remainder follows the dividend; product and quotient follow the sign xor.
  assign o_neg      = (i_in_op == MD_REM) ? w_sa : (w_sa ^ w_sb);

  assign w_prod = i_res_neg ? -i_acc : i_acc;
  assign w_quo  = i_res_neg ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
  assign w_rem  = i_res_neg ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];

  always_comb begin
    o_result = w_rem;
    case (i_res_op)
      MD_MUL:                       o_result = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              o_result = w_quo;
      default:                      o_result = w_rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one bit per cycle over
// XLEN cycles, with valid/ready handshakes on both request and result sides.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [CNT_W-1:0]  r_cnt;

  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg;
  logic              w_accept;
  logic              w_div0;
  logic              w_ovf;
  logic              w_last;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_rs;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_nxt;

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .i_in_op   (op),
    .i_a       (rs1_val),
    .i_b       (rs2_val),
    .o_a_mag   (w_a_mag),
    .o_b_mag   (w_b_mag),
    .o_neg     (w_neg),
    .i_res_op  (r_op),
    .i_res_neg (r_neg),
    .i_acc     (r_acc),
    .o_result  (result)
  );

  assign w_accept = (r_state == ST_IDLE) && in_valid && !kill;
  assign w_div0   = op[2] && (rs2_val == '0);
  assign w_ovf    = ((op == MD_DIV) || (op == MD_REM)) &&
                    (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
  assign w_last   = (r_cnt == CNT_W'(XLEN-1));

  // Multiply: low half holds the remaining multiplier bits, high half the partial product.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
  assign w_rs      = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff    = w_rs - {1'b0, r_b};
  assign w_div_nxt = w_diff[XLEN] ? {w_rs[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next = (w_div0 || w_ovf) ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (kill)        w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (kill || out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_neg <= 1'b0;
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= op;
      r_rd  <= rd_in;
      r_cnt <= '0;
      r_b   <= op[2] ? w_b_mag : w_a_mag;
      // Special cases preload the final {remainder, quotient} with no sign fixup.
      if (w_div0) begin
        r_acc <= {rs1_val, {XLEN{1'b1}}};
        r_neg <= 1'b0;
      end else if (w_ovf) begin
        r_acc <= {{XLEN{1'b0}}, rs1_val};
        r_neg <= 1'b0;
      end else begin
        r_acc <= {{XLEN{1'b0}}, (op[2] ? w_a_mag : w_b_mag)};
        r_neg <= w_neg;
      end
    end else if ((r_state == ST_CALC) && !kill) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
    end
  end

  assign rd_out = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 64-bit and 32-bit instances, hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_kill, a_out_valid, a_out_ready, a_busy;
  logic [2:0]  a_op;
  logic [63:0] a_rs1, a_rs2, a_result;
  logic [4:0]  a_rd_in, a_rd_out;

  logic        b_in_valid, b_in_ready, b_kill, b_out_valid, b_out_ready, b_busy;
  logic [2:0]  b_op;
  logic [31:0] b_rs1, b_rs2, b_result;
  logic [4:0]  b_rd_in, b_rd_out;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .op(a_op),
    .rs1_val(a_rs1), .rs2_val(a_rs2), .rd_in(a_rd_in), .kill(a_kill),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result),
    .rd_out(a_rd_out), .busy(a_busy)
  );

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
    .rs1_val(b_rs1), .rs2_val(b_rs2), .rd_in(b_rd_in), .kill(b_kill),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
    .rd_out(b_rd_out), .busy(b_busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h required 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w32, input logic [2:0] op, input logic [63:0] x,
                       input logic [63:0] y, input logic [4:0] rd);
    if (w32) begin
      b_op = op; b_rs1 = x[31:0]; b_rs2 = y[31:0]; b_rd_in = rd; b_in_valid = 1'b1;
    end else begin
      a_op = op; a_rs1 = x; a_rs2 = y; a_rd_in = rd; a_in_valid = 1'b1;
    end
    step();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit w32, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(w32 ? b_out_valid : a_out_valid) && lat < 200);
  endtask

  task automatic drain(input bit w32, input string tag);
    if (w32) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    chk({tag, " out_valid after accept"}, w32 ? b_out_valid : a_out_valid, 0);
    chk({tag, " in_ready after accept"}, w32 ? b_in_ready : a_in_ready, 1);
  endtask

  task automatic run(input bit w32, input string tag, input logic [2:0] op,
                     input logic [63:0] x, input logic [63:0] y, input logic [4:0] rd,
                     input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(w32, op, x, y, rd);
    wait_valid(w32, lat);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, w32 ? {32'h0, b_result} : a_result, exp);
    chk({tag, " rd_out"}, w32 ? b_rd_out : a_rd_out, rd);
    drain(w32, tag);
  endtask

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1;
    a_in_valid = 0; a_kill = 0; a_out_ready = 0; a_op = 0; a_rs1 = 0; a_rs2 = 0; a_rd_in = 0;
    b_in_valid = 0; b_kill = 0; b_out_ready = 0; b_op = 0; b_rs1 = 0; b_rs2 = 0; b_rd_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", a_in_ready, 1);
    chk("reset out_valid", a_out_valid, 0);
    chk("reset busy", a_busy, 0);
    chk("reset result", a_result, 0);
    chk("reset rd_out", a_rd_out, 0);
    chk("reset32 in_ready", b_in_ready, 1);
    chk("reset32 busy", b_busy, 0);
    rst = 1'b0;
    step();

    run(0, "mul 7*-3",   MD_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
        64'hFFFF_FFFF_FFFF_FFEB, 64);
    run(0, "mulhu ones", MD_MULHU, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64);
    run(0, "mulh ones",  MD_MULH,  '1, '1, 5'd7, 64'h0, 64);
    run(1, "div32 -7/2", MD_DIV,   64'hFFFF_FFF9, 64'd2, 5'd8, 64'h0000_0000_FFFF_FFFD, 32);
    run(1, "rem32 -7%2", MD_REM,   64'hFFFF_FFF9, 64'd2, 5'd9, 64'h0000_0000_FFFF_FFFF, 32);
    run(0, "divu by 0",  MD_DIVU,  64'd100, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run(0, "rem by 0",   MD_REM,   64'd100, 64'd0, 5'd11, 64'd100, 1);
    run(0, "div ovf",    MD_DIV,   64'h8000_0000_0000_0000, '1, 5'd12,
        64'h8000_0000_0000_0000, 1);
    run(0, "rem ovf",    MD_REM,   64'h8000_0000_0000_0000, '1, 5'd13, 64'h0, 1);

    // Backpressure: result must hold while the consumer stalls.
    issue(0, MD_MUL, 64'd3, 64'd5, 5'd14);
    wait_valid(0, lat);
    chk("bp latency", lat, 64);
    repeat (5) begin
      step();
      chk("bp result held", a_result, 64'd15);
      chk("bp in_ready low", a_in_ready, 0);
      chk("bp out_valid held", a_out_valid, 1);
    end
    drain(0, "bp");

    // Kill during CALC.
    issue(0, MD_MULHU, '1, '1, 5'd15);
    repeat (9) step();
    a_kill = 1'b1;
    step();
    a_kill = 1'b0;
    chk("kill in_ready", a_in_ready, 1);
    chk("kill busy", a_busy, 0);
    chk("kill out_valid", a_out_valid, 0);
    seen = 1'b0;
    repeat (80) begin
      step();
      if (a_out_valid) seen = 1'b1;
    end
    chk("kill no late result", seen, 0);

    // Kill in IDLE beats a simultaneous request.
    a_op = MD_MUL; a_rs1 = 64'd2; a_rs2 = 64'd2; a_in_valid = 1'b1; a_kill = 1'b1;
    step();
    a_in_valid = 1'b0; a_kill = 1'b0;
    chk("idle kill busy", a_busy, 0);
    chk("idle kill in_ready", a_in_ready, 1);

    // Asynchronous reset mid-operation.
    issue(0, MD_MUL, 64'd9, 64'd9, 5'd16);
    repeat (20) step();
    #2 rst = 1'b1;
    #1;
    chk("rst mid in_ready", a_in_ready, 1);
    chk("rst mid out_valid", a_out_valid, 0);
    chk("rst mid busy", a_busy, 0);
    chk("rst mid result", a_result, 0);
    chk("rst mid rd_out", a_rd_out, 0);
    step();
    rst = 1'b0;
    step();
    run(0, "div after rst", MD_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd17,
        64'hFFFF_FFFF_FFFF_FFF2, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
